// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port numbering, packet geometry and the
// output arbiter state encoding.
package noc_pkg;

    localparam int NUM_PORTS        = 5;
    localparam int PACKET_SIZE      = 32;
    localparam int FLIT_SIZE        = 4;
    localparam int FLITS_PER_PACKET = PACKET_SIZE / FLIT_SIZE;
    localparam int PTR_W            = 3;
    localparam int CNT_W            = $clog2(FLITS_PER_PACKET);

    localparam logic [PTR_W-1:0] PORT_LOCAL = 3'd0;
    localparam logic [PTR_W-1:0] PORT_NORTH = 3'd1;
    localparam logic [PTR_W-1:0] PORT_SOUTH = 3'd2;
    localparam logic [PTR_W-1:0] PORT_EAST  = 3'd3;
    localparam logic [PTR_W-1:0] PORT_WEST  = 3'd4;

    // Two-bit encoding leaves spare codes; the FSM folds them back into IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set request bit scanning circularly
// upward from the pointer.
module rr_priority_picker
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] request,
    input  logic [PTR_W-1:0]     pointer,
    output logic [NUM_PORTS-1:0] winner_onehot,
    output logic [PTR_W-1:0]     winner_index,
    output logic                 any_req
);

    int idx;

    always_comb begin
        winner_onehot = '0;
        winner_index  = '0;
        any_req       = 1'b0;
        idx           = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(pointer) + k) % NUM_PORTS;
            if (!any_req && request[idx]) begin
                any_req            = 1'b1;
                winner_index       = PTR_W'(idx);
                winner_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Per-output switch allocator: round-robin grant held for a whole packet,
// flit pacing against downstream back-pressure.
module output_arbiter
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] request,
    input  logic                 dest_full,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PTR_W-1:0]     grant_index,
    output logic [NUM_PORTS-1:0] stall_vector,
    output logic                 write_en,
    output logic                 packet_done,
    output logic                 busy
);

    arb_state_e             state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]       grant_index_q, grant_index_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_PORTS-1:0]   win_onehot;
    logic [PTR_W-1:0]       win_index;
    logic                   any_req;
    logic                   last_flit;

    rr_priority_picker u_picker (
        .request       (request),
        .pointer       (ptr_q),
        .winner_onehot (win_onehot),
        .winner_index  (win_index),
        .any_req       (any_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_index_q <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_index_q <= grant_index_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign last_flit = (cnt_q == CNT_W'(FLITS_PER_PACKET - 1));

    // Requests are only looked at in IDLE; a packet ends solely on its flit count.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_index_d = grant_index_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d       = win_onehot;
                    grant_index_d = win_index;
                    cnt_d         = '0;
                    state_d       = ST_XFER;
                end
            end
            ST_XFER: begin
                if (write_en) begin
                    if (last_flit) begin
                        grant_d = '0;
                        cnt_d   = '0;
                        ptr_d   = (grant_index_q == PTR_W'(NUM_PORTS - 1))
                                  ? '0 : grant_index_q + 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy         = (state_q == ST_XFER);
        write_en     = (state_q == ST_XFER) && !dest_full;
        packet_done  = write_en && last_flit;
        stall_vector = request & ~(grant_q & {NUM_PORTS{write_en}});
    end

    assign grant       = grant_q;
    assign grant_index = grant_index_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: cycle table for single-grant and
// back-pressure traffic, hand sequences for fairness, drop, wrap and reset.
module tb_output_arbiter;

    logic       clk;
    logic       reset;
    logic [4:0] request;
    logic       dest_full;
    logic [4:0] grant;
    logic [2:0] grant_index;
    logic [4:0] stall_vector;
    logic       write_en;
    logic       packet_done;
    logic       busy;

    int total;
    int bad;

    typedef struct {
        logic [4:0] req;
        logic       full;
        logic [4:0] g;
        logic [2:0] gi;
        logic [4:0] st;
        logic       we;
        logic       pd;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];

    output_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .request      (request),
        .dest_full    (dest_full),
        .grant        (grant),
        .grant_index  (grant_index),
        .stall_vector (stall_vector),
        .write_en     (write_en),
        .packet_done  (packet_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [4:0] req, logic full, logic [4:0] g, logic [2:0] gi,
                                logic [4:0] st, logic we, logic pd, logic bsy);
        vec_t v;
        v.req = req; v.full = full; v.g = g; v.gi = gi;
        v.st = st; v.we = we; v.pd = pd; v.bsy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs(input vec_t v, input string tag);
        check({tag, ".grant"},       8'(grant),        8'(v.g));
        check({tag, ".grant_index"}, 8'(grant_index),  8'(v.gi));
        check({tag, ".stall"},       8'(stall_vector), 8'(v.st));
        check({tag, ".write_en"},    8'(write_en),     8'(v.we));
        check({tag, ".packet_done"}, 8'(packet_done),  8'(v.pd));
        check({tag, ".busy"},        8'(busy),         8'(v.bsy));
    endtask

    // Drive one cycle's inputs, check the outputs mid-cycle, then advance.
    task automatic cyc(input vec_t v, input string tag);
        request   = v.req;
        dest_full = v.full;
        #1;
        check_outputs(v, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One idle arbitration cycle followed by eight uninterrupted flits.
    task automatic packet(input logic [4:0] req, input int w, input logic [2:0] prev_gi,
                          input string tag);
        logic [4:0] g;
        g = 5'(1 << w);
        cyc(mk(req, 1'b0, 5'b0, prev_gi, req, 1'b0, 1'b0, 1'b0), {tag, ".idle"});
        for (int k = 0; k < 8; k++)
            cyc(mk(req, 1'b0, g, 3'(w), req & ~g, 1'b1, (k == 7), 1'b1), {tag, ".flit"});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        request   = 5'b00100;
        dest_full = 1'b0;

        #1;
        check_outputs(mk(5'b00100, 1'b0, 5'b0, 3'd0, 5'b00100, 1'b0, 1'b0, 1'b0), "reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request on port 2, then a back-pressured packet from port 2.
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 3'd0, 5'b00100, 0, 0, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(5'b00100, 0, 5'b00100, 3'd2, 5'b00000, 1, 0, 1));
        tbl.push_back(mk(5'b00000, 0, 5'b00100, 3'd2, 5'b00000, 1, 1, 1));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 3'd2, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 3'd2, 5'b00100, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(5'b00100, 0, 5'b00100, 3'd2, 5'b00000, 1, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(5'b00100, 1, 5'b00100, 3'd2, 5'b00100, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(5'b00100, 0, 5'b00100, 3'd2, 5'b00000, 1, 0, 1));
        tbl.push_back(mk(5'b00000, 0, 5'b00100, 3'd2, 5'b00000, 1, 1, 1));
        tbl.push_back(mk(5'b00000, 1, 5'b00000, 3'd2, 5'b00000, 0, 0, 0));
        foreach (tbl[i]) cyc(tbl[i], $sformatf("tbl%0d", i));

        // Fairness from a fresh pointer: ports 0,1,2,3,4,0.
        do_reset();
        for (int r = 0; r < 6; r++)
            packet(5'b11111, r % 5, (r == 0) ? 3'd0 : 3'((r - 1) % 5), $sformatf("rr%0d", r));
        cyc(mk(5'b00000, 0, 5'b00000, 3'd0, 5'b00000, 0, 0, 0), "rr.end");

        // Request drop: port 1 releases after two flits, port 0 meanwhile stalls.
        cyc(mk(5'b00010, 0, 5'b00000, 3'd0, 5'b00010, 0, 0, 0), "drop.idle");
        for (int k = 0; k < 2; k++)
            cyc(mk(5'b00010, 0, 5'b00010, 3'd1, 5'b00000, 1, 0, 1), "drop.held");
        for (int k = 2; k < 8; k++)
            cyc(mk(5'b00001, 0, 5'b00010, 3'd1, 5'b00001, 1, (k == 7), 1), "drop.released");

        // Pointer wrap: port 3 completes, then 10001 must pick 4 before 0.
        packet(5'b01000, 3, 3'd1, "wrap.p3");
        packet(5'b10001, 4, 3'd3, "wrap.p4");
        packet(5'b10001, 0, 3'd4, "wrap.p0");
        cyc(mk(5'b00000, 0, 5'b00000, 3'd0, 5'b00000, 0, 0, 0), "wrap.end");

        // Reset on flit 5 of a port-1 packet, then a clean full packet.
        cyc(mk(5'b00010, 0, 5'b00000, 3'd0, 5'b00010, 0, 0, 0), "mid.idle");
        for (int k = 0; k < 4; k++)
            cyc(mk(5'b00010, 0, 5'b00010, 3'd1, 5'b00000, 1, 0, 1), "mid.flit");
        request = 5'b00010;
        #1;
        check_outputs(mk(5'b00010, 0, 5'b00010, 3'd1, 5'b00000, 1, 0, 1), "mid.flit5");
        reset = 1'b1;
        #1;
        check_outputs(mk(5'b00010, 0, 5'b00000, 3'd0, 5'b00010, 0, 0, 0), "mid.reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        packet(5'b00010, 1, 3'd0, "after");
        cyc(mk(5'b00000, 0, 5'b00000, 3'd1, 5'b00000, 0, 0, 0), "after.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
